// File: rtl/apb4_cmd_master.sv
// Single-outstanding APB4 master: valid/ready command in, APB4 SETUP/ACCESS out, valid/ready response back.
// Latency: 4 cycles per zero-wait transfer; a programmable wait-state limit aborts transfers to a hung slave.
module apb4_cmd_master #(
  parameter int unsigned ADDRWIDTH = 12,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic                 pclk,
  input  logic                 presetn,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [ADDRWIDTH-1:0] cmd_addr,
  input  logic                 cmd_write,
  input  logic [31:0]          cmd_wdata,
  input  logic [3:0]           cmd_strb,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [31:0]          rsp_rdata,
  output logic                 rsp_slverr,
  output logic                 rsp_timeout,
  output logic                 psel,
  output logic                 penable,
  output logic                 pwrite,
  output logic [ADDRWIDTH-1:0] paddr,
  output logic [31:0]          pwdata,
  output logic [3:0]           pstrb,
  input  logic [31:0]          prdata,
  input  logic                 pready,
  input  logic                 pslverr
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);
  localparam logic [15:0] WAIT_MAX  = 16'hFFFF;

  state_t      state, state_nxt;
  logic [15:0] wait_cnt;
  logic        timeout_hit;
  logic        cmd_take;

  // pready in the same cycle as the last allowed wait state still completes normally
  assign timeout_hit = (TIMEOUT != 0) && !pready && (wait_cnt == WAIT_LAST);
  assign cmd_take    = (state == IDLE) && cmd_valid;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cmd_valid) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (pready || timeout_hit) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = 1'b0;
    psel      = 1'b0;
    penable   = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      IDLE:    cmd_ready = 1'b1;
      SETUP:   psel      = 1'b1;
      ACCESS:  begin
        psel    = 1'b1;
        penable = 1'b1;
      end
      RESP:    rsp_valid = 1'b1;
      default: cmd_ready = 1'b0;
    endcase
  end

  // APB request fields hold their last values between transfers
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      paddr    <= '0;
      pwrite   <= 1'b0;
      pwdata   <= '0;
      pstrb    <= '0;
      wait_cnt <= '0;
    end else if (cmd_take) begin
      paddr    <= cmd_addr;
      pwrite   <= cmd_write;
      pwdata   <= cmd_write ? cmd_wdata : 32'd0;
      pstrb    <= cmd_write ? cmd_strb : 4'd0;
      wait_cnt <= '0;
    end else if (state == ACCESS && !pready && wait_cnt != WAIT_MAX) begin
      wait_cnt <= wait_cnt + 16'd1;
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      rsp_rdata   <= '0;
      rsp_slverr  <= 1'b0;
      rsp_timeout <= 1'b0;
    end else if (state == ACCESS) begin
      if (pready) begin
        rsp_rdata   <= pwrite ? 32'd0 : prdata;
        rsp_slverr  <= pslverr;
        rsp_timeout <= 1'b0;
      end else if (timeout_hit) begin
        rsp_rdata   <= 32'd0;
        rsp_slverr  <= 1'b1;
        rsp_timeout <= 1'b1;
      end
    end
  end

endmodule
